// File: rtl/sky130_iobuf_pkg.sv
// Shared definitions for the sky130 pad-control sequencer.
// Contents:
//   - tech_cfg bit indices for the sky130 GPIO cell control pins
//   - drive-mode (DM) encodings
//   - sequencer state type
//   - pack_tech(): builds the low 16 tech_cfg bits for a powered pad
package sky130_iobuf_pkg;

  localparam int unsigned HLD_H_N_BIT          = 0;
  localparam int unsigned ENABLE_H_BIT         = 1;
  localparam int unsigned ENABLE_INP_H_BIT     = 2;
  localparam int unsigned ENABLE_VDDA_H_BIT    = 3;
  localparam int unsigned ENABLE_VSWITCH_H_BIT = 4;
  localparam int unsigned ENABLE_VDDIO_BIT     = 5;
  localparam int unsigned IB_MODE_SEL_BIT      = 6;
  localparam int unsigned VTRIP_SEL_BIT        = 7;
  localparam int unsigned SLOW_BIT             = 8;
  localparam int unsigned HLD_OVR_BIT          = 9;
  localparam int unsigned ANALOG_EN_BIT        = 10;
  localparam int unsigned ANALOG_SEL_BIT       = 11;
  localparam int unsigned ANALOG_POL_BIT       = 12;
  localparam int unsigned DM_LSB               = 13;

  localparam logic [2:0] DM_HIZ    = 3'b000;
  localparam logic [2:0] DM_PD     = 3'b010;
  localparam logic [2:0] DM_PU     = 3'b011;
  localparam logic [2:0] DM_STRONG = 3'b110;

  typedef enum logic [1:0] {OFF, ENABLE, ACTIVE, HOLD} iobuf_state_e;

  // Control word for a pad whose supplies are up; the static analog/mode bits stay 0.
  function automatic logic [15:0] pack_tech(input logic       hld_n,
                                            input logic [2:0] dm,
                                            input logic       slow,
                                            input logic       vtrip);
    logic [15:0] t;
    t                       = '0;
    t[HLD_H_N_BIT]          = hld_n;
    t[ENABLE_H_BIT]         = 1'b1;
    t[ENABLE_INP_H_BIT]     = 1'b1;
    t[ENABLE_VDDA_H_BIT]    = 1'b1;
    t[ENABLE_VSWITCH_H_BIT] = 1'b1;
    t[ENABLE_VDDIO_BIT]     = 1'b1;
    t[IB_MODE_SEL_BIT]      = 1'b0;
    t[VTRIP_SEL_BIT]        = vtrip;
    t[SLOW_BIT]             = slow;
    t[HLD_OVR_BIT]          = 1'b0;
    t[ANALOG_EN_BIT]        = 1'b0;
    t[ANALOG_SEL_BIT]       = 1'b0;
    t[ANALOG_POL_BIT]       = 1'b0;
    t[DM_LSB +: 3]          = dm;
    return t;
  endfunction

endpackage

// File: rtl/sky130_iobuf_cfg_decode.sv
// Translates the generic pad cfg nibble into sky130 DM/SLOW/VTRIP.
// Ports:
//   cfg   in  4  [0] pull_en, [1] pull_up, [2] slew limit, [3] schmitt
//   dm    out 3  drive mode
//   slow  out 1  slew-limited output
//   vtrip out 1  VTRIP_SEL (0 selects the schmitt/CMOS threshold)
module sky130_iobuf_cfg_decode
  import sky130_iobuf_pkg::*;
(
  input  logic [3:0] cfg,
  output logic [2:0] dm,
  output logic       slow,
  output logic       vtrip
);

  always_comb begin
    dm = DM_STRONG;
    if (cfg[0]) begin
      dm = cfg[1] ? DM_PU : DM_PD;
    end
  end

  assign slow  = cfg[2];
  assign vtrip = ~cfg[3];

endmodule

// File: rtl/sky130_iobuf_seq.sv
// Pad-control sequencer for one sky130 GPIO: power-up enable/settle/hold-release,
// cfg translation, and hold-protected live cfg updates.
// Optional feature macro: SKY130_IOBUF_SEQ_TIMEOUT_EN adds POC_TIMEOUT and timeout_err.
// Ports:
//   clk, nreset          clock, synchronous active-low reset
//   poc_ok               IO supplies valid (already synchronised)
//   cfg_valid/cfg_ready  cfg handshake, accepted only while the pad is active
//   cfg[7:0]             pull_en, pull_up, slew, schmitt, ds (ds ignored)
//   core_ie, core_oen    core input enable / active-low output enable
//   ie, oen              gated enables to the iobuf
//   tech_cfg             sky130 control pins to the iobuf
//   active               pad operational
//   timeout_err          (macro only) sticky: supplies not valid within POC_TIMEOUT cycles
module sky130_iobuf_seq
  import sky130_iobuf_pkg::*;
#(
  parameter int unsigned TECH_CFG_WIDTH = 16,
  parameter int unsigned ENABLE_CYCLES  = 16,
  parameter int unsigned HOLD_CYCLES    = 4,
  parameter int unsigned CNT_W          = 8
`ifdef SKY130_IOBUF_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned POC_TIMEOUT    = 1024
`endif
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      poc_ok,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [7:0]                cfg,
  input  logic                      core_ie,
  input  logic                      core_oen,
  output logic                      ie,
  output logic                      oen,
  output logic [TECH_CFG_WIDTH-1:0] tech_cfg,
  output logic                      active
`ifdef SKY130_IOBUF_SEQ_TIMEOUT_EN
  ,
  output logic                      timeout_err
`endif
);

  localparam logic [CNT_W-1:0] ENABLE_LAST = CNT_W'(ENABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  iobuf_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       cfg_q, cfg_d;
  logic [15:0]      tc_q;
  logic             ie_q, oen_q;
  logic             handshake;
  logic [2:0]       dm;
  logic             slow, vtrip;
  logic             unused_ds;

  assign unused_ds = ^cfg[7:4];

  assign handshake = cfg_valid & (state_q == ACTIVE);
  // Decode the value cfg_q is about to hold so new DM lands on the first HOLD cycle.
  assign cfg_d     = handshake ? cfg[3:0] : cfg_q;

  sky130_iobuf_cfg_decode u_decode (
    .cfg   (cfg_d),
    .dm    (dm),
    .slow  (slow),
    .vtrip (vtrip)
  );

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= OFF;
      cnt_q   <= '0;
      cfg_q   <= '0;
      tc_q    <= '0;
      ie_q    <= 1'b0;
      oen_q   <= 1'b1;
    end else begin
      // A handshake coinciding with poc_ok loss is still captured.
      if (handshake) begin
        cfg_q <= cfg[3:0];
      end
      if (!poc_ok) begin
        state_q <= OFF;
        cnt_q   <= '0;
        tc_q    <= '0;
        ie_q    <= 1'b0;
        oen_q   <= 1'b1;
      end else begin
        unique case (state_q)
          OFF: begin
            state_q <= ENABLE;
            cnt_q   <= '0;
            tc_q    <= pack_tech(1'b0, dm, slow, vtrip);
          end
          ENABLE: begin
            tc_q <= pack_tech(cnt_q == ENABLE_LAST, dm, slow, vtrip);
            if (cnt_q == ENABLE_LAST) begin
              state_q <= ACTIVE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ACTIVE: begin
            if (handshake) begin
              state_q <= HOLD;
              cnt_q   <= '0;
              tc_q    <= pack_tech(1'b0, dm, slow, vtrip);
              ie_q    <= core_ie;
              oen_q   <= core_oen;
            end
          end
          HOLD: begin
            if (cnt_q == HOLD_LAST) begin
              state_q           <= ACTIVE;
              tc_q[HLD_H_N_BIT] <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: state_q <= OFF;
        endcase
      end
    end
  end

  assign active    = (state_q == ACTIVE);
  assign cfg_ready = (state_q == ACTIVE);
  // Zero-latency passthrough only while active; otherwise the registered safe/held values.
  assign ie        = active ? core_ie  : ie_q;
  assign oen       = active ? core_oen : oen_q;

  always_comb begin
    tech_cfg       = '0;
    tech_cfg[15:0] = tc_q;
  end

`ifdef SKY130_IOBUF_SEQ_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(POC_TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            timeout_q;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else if ((state_q == OFF) && !poc_ok) begin
      if (to_cnt_q != TO_W'(POC_TIMEOUT)) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
      if (to_cnt_q == TO_W'(POC_TIMEOUT - 1)) begin
        timeout_q <= 1'b1;
      end
    end else begin
      to_cnt_q <= '0;
    end
  end

  assign timeout_err = timeout_q;
`endif

endmodule

// File: tb/tb_sky130_iobuf_seq.sv
module tb_sky130_iobuf_seq;

  localparam int EN_CYC  = 16;
  localparam int HLD_CYC = 4;
  localparam int TO_CYC  = 32;

  logic        clk;
  logic        nreset;
  logic        poc_ok;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg;
  logic        core_ie;
  logic        core_oen;
  logic        ie;
  logic        oen;
  logic [15:0] tech_cfg;
  logic        active;
`ifdef SKY130_IOBUF_SEQ_TIMEOUT_EN
  logic        timeout_err;
`endif

  sky130_iobuf_seq #(
    .TECH_CFG_WIDTH (16),
    .ENABLE_CYCLES  (EN_CYC),
    .HOLD_CYCLES    (HLD_CYC),
    .CNT_W          (8)
`ifdef SKY130_IOBUF_SEQ_TIMEOUT_EN
    ,
    .POC_TIMEOUT    (TO_CYC)
`endif
  ) dut (
    .clk         (clk),
    .nreset      (nreset),
    .poc_ok      (poc_ok),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg         (cfg),
    .core_ie     (core_ie),
    .core_oen    (core_oen),
    .ie          (ie),
    .oen         (oen),
    .tech_cfg    (tech_cfg),
    .active      (active)
`ifdef SKY130_IOBUF_SEQ_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] tc;
    logic        ie;
    logic        oen;
    logic        rdy;
    logic        act;
    logic        terr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model: 0 off, 1 enable, 2 active, 3 hold; cnt counts down remaining cycles.
  int         m_st = 0;
  int         m_cnt = 0;
  logic [3:0] m_cfg = '0;
  logic       m_ie_h = 1'b0;
  logic       m_oen_h = 1'b1;
  int         m_to = 0;
  logic       m_terr = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [2:0] dm_of(input logic [3:0] c);
    if (c[0] && c[1]) return 3'b011;
    if (c[0])         return 3'b010;
    return 3'b110;
  endfunction

  task automatic model_step();
    logic hs;
    if (!nreset) begin
      m_st = 0; m_cnt = 0; m_cfg = '0; m_ie_h = 1'b0; m_oen_h = 1'b1; m_to = 0; m_terr = 1'b0;
    end else begin
      hs = (m_st == 2) && cfg_valid;
      if (m_st == 0 && !poc_ok) begin
        m_to++;
        if (m_to >= TO_CYC) m_terr = 1'b1;
      end else begin
        m_to = 0;
      end
      if (hs) m_cfg = cfg[3:0];
      if (!poc_ok) begin
        m_st = 0;
      end else begin
        case (m_st)
          0: begin m_st = 1; m_cnt = EN_CYC; end
          1: begin m_cnt--; if (m_cnt == 0) m_st = 2; end
          2: if (hs) begin
               m_st = 3; m_cnt = HLD_CYC; m_ie_h = core_ie; m_oen_h = core_oen;
             end
          default: begin m_cnt--; if (m_cnt == 0) m_st = 2; end
        endcase
      end
    end
  endtask

  task automatic model_out(output exp_t e);
    e = '0;
    if (m_st != 0) begin
      e.tc[5:1]   = 5'b11111;
      e.tc[0]     = (m_st == 2);
      e.tc[7]     = ~m_cfg[3];
      e.tc[8]     = m_cfg[2];
      e.tc[15:13] = dm_of(m_cfg);
    end
    e.ie   = (m_st == 2) ? core_ie  : (m_st == 3) ? m_ie_h  : 1'b0;
    e.oen  = (m_st == 2) ? core_oen : (m_st == 3) ? m_oen_h : 1'b1;
    e.rdy  = (m_st == 2);
    e.act  = (m_st == 2);
    e.terr = m_terr;
  endtask

  // One clock: randomise core enables, predict, clock, compare at the falling edge.
  task automatic tick();
    exp_t e;
    core_ie  = 1'($urandom_range(0, 1));
    core_oen = 1'($urandom_range(0, 1));
    model_step();
    model_out(e);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    e = sb.pop_front();
    check_eq("tech_cfg", 32'(tech_cfg), 32'(e.tc));
    check_eq("ie_oen_rdy_act", {28'd0, ie, oen, cfg_ready, active},
             {28'd0, e.ie, e.oen, e.rdy, e.act});
`ifdef SKY130_IOBUF_SEQ_TIMEOUT_EN
    check_eq("timeout_err", 32'(timeout_err), 32'(e.terr));
`endif
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         en_rise, hld_rise, p, n, fall_cyc, rise_cyc, falls;
    logic       prev_hld, fire;
    logic [3:0] ds;

    nreset = 1'b0; poc_ok = 1'b0; cfg_valid = 1'b0; cfg = 8'h00;
    core_ie = 1'b0; core_oen = 1'b1;

    // Reset state.
    ticks(2);
    check_eq("reset_tech", 32'(tech_cfg), 32'h0);
    check_eq("reset_oen", 32'(oen), 32'h1);

    // Power-up sequence.
    nreset = 1'b1;
    ticks(3);
    poc_ok = 1'b1;
    p = cyc; en_rise = -1; hld_rise = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (tech_cfg[1] && en_rise < 0) en_rise = cyc;
      if (tech_cfg[0] && hld_rise < 0) hld_rise = cyc;
    end
    check_eq("poc_to_en", 32'(en_rise - p), 32'd1);
    check_eq("en_to_hld", 32'(hld_rise - en_rise), 32'(EN_CYC));

    // Single cfg update with hold-protected handshake.
    cfg = 8'h03; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    check_eq("upd_hld_low", 32'(tech_cfg[0]), 32'h0);
    check_eq("upd_dm", 32'(tech_cfg[15:13]), 32'(3'b011));
    n = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tech_cfg[0]) break;
      n++;
    end
    check_eq("hold_len", 32'(n), 32'(HLD_CYC));

    // Sweep all cfg[3:0] with random ds bits.
    for (int i = 0; i < 16; i++) begin
      ds = 4'($urandom_range(0, 15));
      cfg = {ds, 4'(i)}; cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      check_eq("sweep_dm", 32'(tech_cfg[15:13]), 32'(dm_of(4'(i))));
      ticks(HLD_CYC + 1);
    end

    // poc_ok loss during HOLD, then replay with retained cfg.
    cfg = 8'h01; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    tick();
    poc_ok = 1'b0;
    tick();
    check_eq("poc_fall_en", 32'(tech_cfg[5:0]), 32'h0);
    check_eq("poc_fall_oen_act", {30'd0, oen, active}, 32'b10);
    ticks(2);
    poc_ok = 1'b1;
    ticks(EN_CYC + 2);
    check_eq("replay_dm", 32'(tech_cfg[15:13]), 32'(3'b010));
    check_eq("replay_hld", 32'(tech_cfg[0]), 32'h1);

    // cfg_valid held through ENABLE: one acceptance, on the first ACTIVE cycle.
    poc_ok = 1'b0;
    tick();
    poc_ok = 1'b1; cfg = 8'h05; cfg_valid = 1'b1;
    prev_hld = tech_cfg[0]; falls = 0; rise_cyc = -1; fall_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      fire = cfg_ready & cfg_valid;
      tick();
      if (fire) cfg_valid = 1'b0;
      if (tech_cfg[0] && !prev_hld && rise_cyc < 0) rise_cyc = cyc;
      if (!tech_cfg[0] && prev_hld) begin
        falls++;
        if (fall_cyc < 0) fall_cyc = cyc;
      end
      prev_hld = tech_cfg[0];
    end
    check_eq("held_valid_holds", 32'(falls), 32'd1);
    check_eq("held_valid_first", 32'(fall_cyc - rise_cyc), 32'd1);

    // Handshake coinciding with poc_ok loss: OFF wins, cfg still captured.
    cfg = 8'h0C; cfg_valid = 1'b1; poc_ok = 1'b0;
    tick();
    cfg_valid = 1'b0;
    check_eq("simul_off", {16'd0, tech_cfg}, 32'h0);
    check_eq("simul_act", 32'(active), 32'h0);
    poc_ok = 1'b1;
    ticks(EN_CYC + 2);
    check_eq("simul_cfg", {29'd0, tech_cfg[15:13]}, 32'(3'b110));
    check_eq("simul_slow_vtrip", {30'd0, tech_cfg[8], tech_cfg[7]}, 32'b10);

    // Reset mid-ENABLE.
    poc_ok = 1'b0;
    tick();
    poc_ok = 1'b1;
    ticks(5);
    nreset = 1'b0;
    tick();
    check_eq("mid_reset", {16'd0, tech_cfg}, 32'h0);
    nreset = 1'b1;
    ticks(EN_CYC + 3);
    check_eq("post_reset_vtrip", 32'(tech_cfg[7]), 32'h1);

`ifdef SKY130_IOBUF_SEQ_TIMEOUT_EN
    nreset = 1'b0; poc_ok = 1'b0;
    tick();
    nreset = 1'b1;
    ticks(TO_CYC - 1);
    check_eq("to_before", 32'(timeout_err), 32'h0);
    tick();
    check_eq("to_set", 32'(timeout_err), 32'h1);
    poc_ok = 1'b1;
    ticks(5);
    check_eq("to_sticky", 32'(timeout_err), 32'h1);
    nreset = 1'b0;
    tick();
    check_eq("to_clear", 32'(timeout_err), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sky130_iobuf_seq.md
Name: sky130_iobuf_seq

Overview:
- Control-side counterpart of the sky130 GPIO buffer wrapper.
- Generates the 16-bit tech_cfg bus and gates core ie/oen for one pad.
- Runs the power-up sequence: ENABLE_H, settle, then hold release.
- Translates the generic 8-bit cfg into sky130 DM/SLOW/VTRIP, and applies live cfg updates through a hold-protected handshake.
- One instance per pad, sitting between the core pad-control register and the iobuf.

Parameters:
- TECH_CFG_WIDTH, 16, width of tech_cfg output; must be ≥16.
- ENABLE_CYCLES, 16, cycles between ENABLE_H rise and hold release; ≥1.
- HOLD_CYCLES, 4, cycles HLD_H_N stays low around a cfg update; ≥1.
- CNT_W, 8, settle counter width; must satisfy 2^CNT_W > max(ENABLE_CYCLES, HOLD_CYCLES).

Ports:
- clk  in  1  core clock.
- nreset  in  1  synchronous active-low reset.
- poc_ok  in  1  power-on-complete, already synchronised; high = IO supplies valid.
- cfg_valid  in  1  new cfg offered.
- cfg_ready  out  1  cfg accepted this cycle when cfg_valid & cfg_ready.
- cfg  in  8  [0] pull_en, [1] pull_up, [2] slew limit, [3] schmitt, [7:4] ds (reserved, ignored).
- core_ie  in  1  core input enable.
- core_oen  in  1  core output enable, active low.
- ie  out  1  to iobuf.
- oen  out  1  to iobuf.
- tech_cfg  out  TECH_CFG_WIDTH  to iobuf.
- active  out  1  pad operational.

Behaviour:
- tech_cfg bit map:
  - 0 HLD_H_N, 1 ENABLE_H, 2 ENABLE_INP_H, 3 ENABLE_VDDA_H, 4 ENABLE_VSWITCH_H, 5 ENABLE_VDDIO
  - 6 IB_MODE_SEL, 7 VTRIP_SEL, 8 SLOW, 9 HLD_OVR, 10 ANALOG_EN, 11 ANALOG_SEL, 12 ANALOG_POL, [15:13] DM
  - bits above 15 are driven 0.
- Static bits: IB_MODE_SEL=0, HLD_OVR=0, ANALOG_EN=0, ANALOG_SEL=0, ANALOG_POL=0.
- Decode, registered into cfg_q: VTRIP_SEL=~cfg[3], SLOW=cfg[2].
- DM from cfg_q:
  - pull_en & pull_up → 3'b011
  - pull_en & ~pull_up → 3'b010
  - otherwise → 3'b110
- Reset values (nreset low at clk edge):
  - state=OFF, cfg_q=0, tech_cfg=all 0 (so DM=000 hi-z and HLD_H_N=0).
  - ie=0, oen=1, cfg_ready=0, active=0.
- FSM states:
  - OFF: all enables 0. poc_ok=1 → ENABLE, counter cleared.
  - ENABLE: ENABLE_H, ENABLE_INP_H, ENABLE_VDDA_H, ENABLE_VSWITCH_H, ENABLE_VDDIO=1; DM from cfg_q; HLD_H_N=0. After ENABLE_CYCLES cycles → ACTIVE.
  - ACTIVE: HLD_H_N=1, active=1, cfg_ready=1, ie=core_ie, oen=core_oen (combinational passthrough, 0 latency). cfg handshake → cfg_q loads cfg, go to HOLD.
  - HOLD: HLD_H_N=0, cfg_ready=0, active=0. ie/oen hold values registered at HOLD entry. New DM/SLOW/VTRIP appear on tech_cfg the first HOLD cycle. After HOLD_CYCLES → ACTIVE.
- Update timing: tech_cfg changes only while HLD_H_N=0. HLD_H_N rises exactly HOLD_CYCLES cycles after the handshake edge.
- poc_ok falls in any state → OFF next cycle: ENABLE_* and HLD_H_N drop together, oen=1, ie=0, cfg_q retained. Re-entry replays ENABLE with retained cfg_q.
- cfg_valid outside ACTIVE: not accepted; the requester holds it. cfg_valid must not depend on cfg_ready.
- Simultaneous handshake and poc_ok fall: poc_ok wins; cfg is still captured into cfg_q.
- Reset mid-sequence returns to OFF regardless of counter value.

Optional Feature:
- Macro: SKY130_IOBUF_SEQ_TIMEOUT_EN.
- With macro:
  - Adds parameter POC_TIMEOUT (default 1024) and output timeout_err.
  - In OFF, a counter of width clog2(POC_TIMEOUT+1) runs while nreset=1 and poc_ok=0.
  - On reaching POC_TIMEOUT, timeout_err sets sticky; it clears only on reset.
  - FSM behaviour is unchanged.
- Without macro: no port, no counter.

Decomposition:
- Package sky130_iobuf_pkg holds:
  - tech_cfg bit-index localparams (HLD_H_N_BIT … DM_LSB)
  - DM encodings DM_HIZ=000, DM_PD=010, DM_PU=011, DM_STRONG=110
  - FSM state enum typedef {OFF, ENABLE, ACTIVE, HOLD}.
- One natural sub-module: sky130_iobuf_cfg_decode, combinational cfg_q → DM/SLOW/VTRIP.

Test Plan:
1. Release nreset, poc_ok=1 at cycle 5.
   - ENABLE_H=1 at cycle 6; HLD_H_N=1 and active=1 at cycle 22 (ENABLE_CYCLES=16).
   - DM=110; oen=1 throughout, until active.
2. In ACTIVE, cfg=8'h03 handshake.
   - HLD_H_N=0 next cycle with DM=011 the same cycle; HLD_H_N=1 four cycles later.
   - cfg_ready low for those 4 cycles.
3. Sweep all 16 combinations of cfg[3:0].
   - DM/SLOW/VTRIP match the decode table; ds bits have no effect.
4. poc_ok falls during HOLD.
   - Next cycle tech_cfg[5:0]=0, oen=1, active=0.
   - poc_ok re-rises → ENABLE replays with the last cfg_q.
5. cfg_valid held during ENABLE.
   - cfg_ready=0; accepted on the first ACTIVE cycle; exactly one HOLD entry.
6. SKY130_IOBUF_SEQ_TIMEOUT_EN, POC_TIMEOUT=32, poc_ok=0.
   - timeout_err=1 after 32 cycles and stays set after poc_ok rises; clears on nreset.
